// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: ALU control codes, FSM states
// and small opcode decoders.
package mult_div_unit_pkg;

  localparam logic [4:0] ALUCtrl_MULT  = 5'b11000;
  localparam logic [4:0] ALUCtrl_MULTU = 5'b11001;
  localparam logic [4:0] ALUCtrl_DIV   = 5'b11010;
  localparam logic [4:0] ALUCtrl_DIVU  = 5'b11011;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_MUL  = 2'd1,
    MDU_DIV  = 2'd2,
    MDU_FIX  = 2'd3
  } mdu_state_e;

  function automatic logic is_mul_op(input logic [4:0] ctrl);
    return (ctrl == ALUCtrl_MULT) || (ctrl == ALUCtrl_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [4:0] ctrl);
    return (ctrl == ALUCtrl_DIV) || (ctrl == ALUCtrl_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [4:0] ctrl);
    return (ctrl == ALUCtrl_MULT) || (ctrl == ALUCtrl_DIV);
  endfunction

endpackage

// File: rtl/mult_div_unit_abs_neg.sv
// Combinational conditional two's-complement negate, used both for operand
// magnitudes and for applying the result sign.
module mdu_abs_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result
);

  assign result = negate ? (~value + W'(1)) : value;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the HI/LO registers; one
// multiplier/quotient bit per cycle on a shared 2*WIDTH accumulator.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output mdu_state_e       state
);

  // Handshake: start is taken only in IDLE (and not under flush); busy is high
  // from the accepting edge until HI/LO are written, when done pulses once.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mdu_state_e           state_q, state_d;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     mag_a, mag_b, raw_a;
  logic                 sign_q, sign_r, div_zero, is_mul;
  logic                 accept, last_iter, signed_op;
  logic [WIDTH-1:0]     abs_a, abs_b, quo, rem;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH:0]       mul_sum, div_top;
  logic [WIDTH-1:0]     div_diff;
  logic                 div_fits;
  logic [2*WIDTH-1:0]   mul_next, div_next;

  assign signed_op = is_signed_op(alu_ctrl);
  assign accept    = (state_q == MDU_IDLE) && start && !flush &&
                     (is_mul_op(alu_ctrl) || is_div_op(alu_ctrl));
  assign last_iter = (cnt == CW'(WIDTH - 1));

  mdu_abs_neg #(.W(WIDTH))   u_abs_a (.value(op_a), .negate(signed_op & op_a[WIDTH-1]), .result(abs_a));
  mdu_abs_neg #(.W(WIDTH))   u_abs_b (.value(op_b), .negate(signed_op & op_b[WIDTH-1]), .result(abs_b));
  mdu_abs_neg #(.W(2*WIDTH)) u_prod  (.value(acc), .negate(sign_q), .result(prod));
  mdu_abs_neg #(.W(WIDTH))   u_quo   (.value(acc[WIDTH-1:0]), .negate(sign_q), .result(quo));
  mdu_abs_neg #(.W(WIDTH))   u_rem   (.value(acc[2*WIDTH-1:WIDTH]), .negate(sign_r), .result(rem));

  // Multiply: acc = {partial, multiplier}; add on the LSB, then shift right.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}; trial-subtract the shifted remainder.
  assign div_top  = acc[2*WIDTH-1:WIDTH-1];
  assign div_fits = (div_top >= {1'b0, mag_b});
  assign div_diff = div_top[WIDTH-1:0] - mag_b;
  assign div_next = {(div_fits ? div_diff : div_top[WIDTH-1:0]), acc[WIDTH-2:0], div_fits};

  always_ff @(posedge clk) begin
    if (rst) state_q <= MDU_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MDU_IDLE: if (accept) state_d = is_mul_op(alu_ctrl) ? MDU_MUL : MDU_DIV;
      MDU_MUL,
      MDU_DIV:  if (last_iter) state_d = MDU_FIX;
      MDU_FIX:  state_d = MDU_IDLE;
      default:  state_d = MDU_IDLE;
    endcase
    if (flush) state_d = MDU_IDLE;
  end

  always_comb begin
    busy  = (state_q != MDU_IDLE);
    state = state_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      acc      <= '0;
      mag_a    <= '0;
      mag_b    <= '0;
      raw_a    <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      div_zero <= 1'b0;
      is_mul   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        cnt <= '0;
      end else begin
        case (state_q)
          MDU_IDLE: begin
            if (wr_hi) hi <= wr_data;
            if (wr_lo) lo <= wr_data;
            if (accept) begin
              mag_a    <= abs_a;
              mag_b    <= abs_b;
              raw_a    <= op_a;
              sign_q   <= signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
              sign_r   <= signed_op & op_a[WIDTH-1];
              div_zero <= (op_b == '0);
              is_mul   <= is_mul_op(alu_ctrl);
              cnt      <= '0;
              acc      <= {{WIDTH{1'b0}}, (is_mul_op(alu_ctrl) ? abs_b : abs_a)};
            end
          end
          MDU_MUL: begin
            acc <= mul_next;
            cnt <= last_iter ? '0 : cnt + CW'(1);
          end
          MDU_DIV: begin
            acc <= div_next;
            cnt <= last_iter ? '0 : cnt + CW'(1);
          end
          MDU_FIX: begin
            done <= 1'b1;
            if (is_mul) begin
              hi <= prod[2*WIDTH-1:WIDTH];
              lo <= prod[WIDTH-1:0];
            end else if (div_zero) begin
              hi <= raw_a;
              lo <= '1;
            end else begin
              hi <= rem;
              lo <= quo;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
